// File: rtl/risk_tile_dma.sv
// risk_tile_dma: tile load/store sequencer for the banked RISK tile memory with credit-protected response FIFO
// Optional RISK_DMA_CONFLICT_CHECK_EN rejects commands whose base tile rows collide in one bank.
module risk_tile_dma #(
  parameter int SZ = 4,
  parameter int LOGCNT = 5,
  parameter int BITS = 18,
  parameter int MEM_LAT = 4,
  parameter int RSP_DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int AW = 10 + LOGCNT,
  localparam int TW = BITS * SZ * SZ
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW-2:0]    cmd_stride_x,
  input  logic [AW-2:0]    cmd_stride_y,
  input  logic [AW-1:0]    cmd_step,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [TW-1:0]    cmd_wdata,
  output logic [AW-1:0]    mem_addr,
  output logic [AW-2:0]    mem_stride_x,
  output logic [AW-2:0]    mem_stride_y,
  output logic [TW-1:0]    mem_dat_w,
  output logic             mem_we,
  input  logic [TW-1:0]    mem_dat_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             err
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int IW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic up, conflict, hs, issue, push, pop, credit;
  logic [AW-1:0] step;
  logic [CNT_W-1:0] cnt, k;
  logic [IW-1:0] infl, wcnt;
  logic [MEM_LAT-1:0] sv, sl;
  logic [TW-1:0] fd [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fl;
  logic [PW-1:0] rd, wr;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = up && state == IDLE;
  assign hs = cmd_valid && cmd_ready;
  assign infl = IW'($countones(sv));
  assign credit = 32'(occ) + 32'(infl) < 32'(RSP_DEPTH);
  assign issue = state == READ && credit;
  assign push = sv[MEM_LAT-1];
  assign pop = rsp_valid && rsp_ready;
  assign mem_we = state == WRITE;
  assign busy = state != IDLE || infl != 0;
  assign rsp_valid = occ != 0;
  assign rsp_data = fd[rd];
  assign rsp_last = rsp_valid && fl[rd];

`ifdef RISK_DMA_CONFLICT_CHECK_EN
  logic [LOGCNT-1:0] bank [SZ];
  logic [LOGCNT-1:0] acc;
  always_comb begin
    acc = cmd_addr[LOGCNT-1:0];
    conflict = 1'b0;
    for (int y = 0; y < SZ; y++) begin
      bank[y] = acc;
      acc = acc + cmd_stride_y[LOGCNT-1:0];
    end
    for (int i = 0; i < SZ; i++)
      for (int j = i + 1; j < SZ; j++)
        conflict = conflict | (bank[i] == bank[j]);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) err <= 1'b0;
    else err <= hs && conflict;
`else
  assign conflict = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (hs && !conflict) state_n = cmd_we ? WRITE : READ;
      WRITE:   state_n = DRAIN;
      READ:    if (issue && k == cnt) state_n = DRAIN;
      default: if (infl == 0 && wcnt == 0) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      up <= 1'b0;
      mem_addr <= '0;
      mem_stride_x <= '0;
      mem_stride_y <= '0;
      mem_dat_w <= '0;
      step <= '0;
      cnt <= '0;
      k <= '0;
      wcnt <= '0;
      sv <= '0;
      sl <= '0;
      fl <= '0;
      rd <= '0;
      wr <= '0;
      occ <= '0;
    end else begin
      state <= state_n;
      up <= 1'b1;
      if (hs && !conflict) begin
        mem_addr <= cmd_addr;
        mem_stride_x <= cmd_stride_x;
        mem_stride_y <= cmd_stride_y;
        mem_dat_w <= cmd_wdata;
        step <= cmd_step;
        cnt <= cmd_count;
        k <= '0;
      end else if (issue) begin
        mem_addr <= mem_addr + step;
        k <= k + 1'b1;
      end
      // write-to-read spacing: counts down MEM_LAT-1 more cycles after the store cycle
      wcnt <= state == WRITE ? IW'(MEM_LAT - 1) : wcnt - IW'(wcnt != 0);
      sv <= MEM_LAT'({sv, issue});
      sl <= MEM_LAT'({sl, issue && k == cnt});
      if (push) begin
        fl[wr] <= sl[MEM_LAT-1];
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      occ <= occ + OW'(push) - OW'(pop);
    end

  always_ff @(posedge clk)
    if (push) fd[wr] <= mem_dat_r;
endmodule

// File: tb/tb_risk_tile_dma.sv
// tb_risk_tile_dma: directed bench with memory model and response scoreboard for risk_tile_dma
module tb_risk_tile_dma;
  localparam int SZ = 4, LOGCNT = 5, BITS = 18, MEM_LAT = 4, RSP_DEPTH = 4, CNT_W = 8;
  localparam int AW = 10 + LOGCNT, TW = BITS * SZ * SZ;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0, mem_we, rsp_valid, rsp_ready = 0, rsp_last, busy, err;
  logic [AW-1:0] cmd_addr = '0, cmd_step = '0, mem_addr;
  logic [AW-2:0] cmd_stride_x = '0, cmd_stride_y = '0, mem_stride_x, mem_stride_y;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [TW-1:0] cmd_wdata = '0, mem_dat_w, mem_dat_r = '0, rsp_data;

  risk_tile_dma #(.SZ(SZ), .LOGCNT(LOGCNT), .BITS(BITS), .MEM_LAT(MEM_LAT), .RSP_DEPTH(RSP_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y), .cmd_step(cmd_step),
    .cmd_count(cmd_count), .cmd_wdata(cmd_wdata), .mem_addr(mem_addr), .mem_stride_x(mem_stride_x),
    .mem_stride_y(mem_stride_y), .mem_dat_w(mem_dat_w), .mem_we(mem_we), .mem_dat_r(mem_dat_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err(err));

  always #5 clk = ~clk;

  typedef struct {logic [TW-1:0] d; logic l;} exp_t;
  exp_t q[$];
  logic [TW-1:0] refm [int];
  logic [TW-1:0] env [int];
  int hist [MEM_LAT+1];
  int cmp = 0, bad = 0, cyc = 0, we_cnt = 0, we_cyc = -1, err_at = -1, popped = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] pat(input int a);
    logic [TW-1:0] t;
    for (int e = 0; e < SZ * SZ; e++) t[e*BITS +: BITS] = BITS'(a) ^ BITS'(e * 12345) ^ 18'h15A5A;
    return t;
  endfunction

  function automatic logic [TW-1:0] tile(input int a);
    return refm.exists(a) ? refm[a] : pat(a);
  endfunction

  function automatic logic conflicts(input int a, input int sy);
`ifdef RISK_DMA_CONFLICT_CHECK_EN
    int b [SZ];
    for (int y = 0; y < SZ; y++) b[y] = (a + sy * y) & ((1 << LOGCNT) - 1);
    for (int i = 0; i < SZ; i++)
      for (int j = i + 1; j < SZ; j++)
        if (b[i] == b[j]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory: data for the address seen MEM_LAT cycles ago is valid at the next capture edge
  always @(negedge clk) begin
    for (int i = MEM_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(mem_addr);
    if (mem_we) env[int'(mem_addr)] = mem_dat_w;
    mem_dat_r = env.exists(hist[MEM_LAT]) ? env[hist[MEM_LAT]] : pat(hist[MEM_LAT]);
  end

  logic hold = 0, pl = 0;
  logic [TW-1:0] pd = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) hold = 0;
    else begin
      chk("err", err, cyc == err_at);
      if (mem_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (hold) begin
        chk("rsp_data_hold", rsp_data, pd);
        chk("rsp_last_hold", rsp_last, pl);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL rsp_extra: got unexpected tile %0h want none", rsp_data);
        end else begin
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_last", rsp_last, e.l);
          popped++;
        end
      end
      hold = rsp_valid && !rsp_ready;
      pd = rsp_data;
      pl = rsp_last;
    end
  end

  task automatic send(input logic we, input int addr, input int sy, input int sx, input int step,
                      input int count, input logic [TW-1:0] wd, output int a);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_we = we;
    cmd_addr = AW'(addr);
    cmd_stride_y = (AW-1)'(sy);
    cmd_stride_x = (AW-1)'(sx);
    cmd_step = AW'(step);
    cmd_count = CNT_W'(count);
    cmd_wdata = wd;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready 0 after %0d cycles want 1", n);
    end
    a = cyc;
    if (cmd_ready) begin
      if (conflicts(addr, sy)) err_at = a + 1;
      else if (we) refm[addr] = wd;
      else for (int i = 0; i <= count; i++) q.push_back('{tile((addr + i * step) & ((1 << AW) - 1)), i == count});
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || rsp_valid || q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, %0d tiles outstanding want 0", name, n, q.size());
    end
  endtask

  initial begin
    int a, s, n, p0;
    logic ok;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_dat_w", mem_dat_w, 0);
    chk("rst_stride_y", mem_stride_y, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 resetn = 1;

    send(1, 'h040, 1, 0, 0, 0, ~pat('h040), s);
    send(0, 'h040, 1, 0, 'h20, 0, '0, a);
    chk("drain_gap", (a - we_cyc) > MEM_LAT, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("load_latency", cyc, a + 2 + MEM_LAT);
    chk("store_data_lit", rsp_data, ~pat('h040));
    chk("store_last_lit", rsp_last, 1);
    @(posedge clk);
    #1 rsp_ready = 1;
    wait_idle("idle_store_load");
    chk("store_we_cycles", we_cnt, 1);

    p0 = popped;
    send(0, 'h000, 1, 'h123, 'h20, 3, '0, a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("burst_addr%0d", i), mem_addr, i * 'h20);
      chk($sformatf("burst_we%0d", i), mem_we, 0);
      if (i == 0) begin
        chk("burst_stride_x", mem_stride_x, 'h123);
        chk("burst_stride_y", mem_stride_y, 1);
        chk("burst_busy", busy, 1);
      end
    end
    wait_idle("idle_burst");
    chk("burst_count", popped - p0, 4);
    chk("burst_busy_done", busy, 0);

    @(posedge clk);
    #1 rsp_ready = 0;
    p0 = popped;
    send(0, 'h100, 1, 0, 'h20, 7, '0, a);
    ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 5 && mem_addr != 'h180) ok = 0;
    end
    chk("stall_addr_held", ok, 1);
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_no_pop", popped - p0, 0);
    @(posedge clk);
    #1 rsp_ready = 1;
    wait_idle("idle_stall");
    chk("stall_all_delivered", popped - p0, 8);

    send(0, 'h7FF0, 1, 0, 'h20, 1, '0, a);
    @(negedge clk);
    chk("wrap_addr0", mem_addr, 'h7FF0);
    @(negedge clk);
    chk("wrap_addr1", mem_addr, 'h0010);
    wait_idle("idle_wrap");

`ifdef RISK_DMA_CONFLICT_CHECK_EN
    p0 = popped;
    send(0, 'h000, 'h20, 0, 'h20, 0, '0, a);
    @(negedge clk);
    chk("conflict_err", err, 1);
    chk("conflict_ready", cmd_ready, 1);
    chk("conflict_no_we", mem_we, 0);
    chk("conflict_not_busy", busy, 0);
    send(0, 'h000, 'h001, 0, 'h20, 0, '0, a);
    wait_idle("idle_conflict");
    chk("conflict_responses", popped - p0, 1);
`endif

    @(posedge clk);
    #1 rsp_ready = 0;
    send(0, 'h200, 1, 0, 'h20, 7, '0, a);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 resetn = 0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_stride_y", mem_stride_y, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_last", rsp_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    q.delete();
    rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ok = ok | rsp_valid;
    end
    chk("mid_rst_no_stale", ok, 0);
    p0 = popped;
    send(0, 'h300, 1, 0, 'h20, 1, '0, a);
    wait_idle("idle_after_reset");
    chk("after_reset_count", popped - p0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
